jtag_regacc: RTL and testbench
==============================

JTAG_REGACC -- requirements
Module: jtag_regacc

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 8, giving the maximum write/read retries before an error response.
REQ-002 SHALL have port clk  in  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid_i in 1 / req_ready_o out 1  debug-side request handshake.
REQ-005 SHALL have ports req_we_i in 1, req_addr_i in 5, req_data_i in 32  request write flag, register index, write data.
REQ-006 SHALL have ports rsp_valid_o out 1 / rsp_ready_i in 1  response handshake.
REQ-007 SHALL have ports rsp_data_o out 32, rsp_err_o out 1  read data (0 for writes), error flag.
REQ-008 SHALL have ports jtag_we_o out 1, jtag_addr_o out 5, jtag_data_o out 32  drive the register file debug write/address/data inputs.
REQ-009 SHALL have port jtag_data_i  in  32  register file debug read data (combinational, no bypass).
REQ-010 SHALL have ports ex_we_i in 1, ex_waddr_i in 5  snooped execute-stage write port to the register file.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on req_valid_i&&req_ready_o, ACCESS->RESP on completion or retry exhaustion, RESP->IDLE on rsp_valid_o&&rsp_ready_i.
REQ-012 SHALL assert req_ready_o only in IDLE; request fields SHALL be latched on acceptance.
REQ-013 SHALL hold jtag_addr_o/jtag_data_o at latched values in ACCESS, 0 otherwise.
REQ-014 SHALL assert jtag_we_o only in ACCESS with latched we=1 and addr!=0.
REQ-015 Write collision: ex_we_i=1 with ex_waddr_i!=0 in an ACCESS write cycle SHALL count as dropped (execute has priority); else the write completes that cycle.
REQ-016 Read collision: ex_we_i=1 with ex_waddr_i==latched addr!=0 in an ACCESS read cycle SHALL be a retry; else jtag_data_i is captured into rsp_data_o.
REQ-017 Each collision SHALL increment a retry counter and remain in ACCESS; when counter reaches MAX_RETRY with another collision, SHALL go to RESP with rsp_err_o=1, rsp_data_o=0.
REQ-018 Addr 0: write SHALL complete in one ACCESS cycle with no jtag_we_o, err=0; read SHALL return 0, err=0, never retry.
REQ-019 Latency without collision: accepted at edge N, ACCESS during N..N+1, rsp_valid_o high after edge N+2.
REQ-020 rsp_valid_o, rsp_data_o, rsp_err_o SHALL be registered and stable until handshake; retry counter SHALL clear on acceptance.
REQ-021 A new request SHALL be accepted no earlier than the cycle after the response handshake.

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, retry counter 0, all outputs 0 except req_ready_o which follows IDLE after release; an in-flight request SHALL be discarded with no response.

Structure
REQ-023 State enum, MAX_RETRY default and retry-counter width SHALL live in the shared core package; register index/data widths SHALL use the existing RegAddrBus/RegBus defines.
REQ-024 Single module; no sub-module.

Verification
REQ-025 Write x5=0xDEADBEEF, ex idle -> jtag_we_o one cycle, addr 5, data 0xDEADBEEF; rsp err=0 after edge N+2.
REQ-026 Write x7 while ex_we_i=1, ex_waddr_i=3 for 2 cycles -> jtag_we_o held 3 cycles, rsp err=0 one cycle after ex idle.
REQ-027 Read x9 with ex writing x9 for MAX_RETRY+1 cycles -> rsp err=1, data 0.
REQ-028 Read x0 / write x0 -> data 0, err=0, jtag_we_o never asserted.
REQ-029 rsp_ready_i held low 5 cycles -> rsp_valid_o/data stable, req_ready_o low; rst pulsed mid-ACCESS -> IDLE, no response.

Source files
------------

// File: rtl/jtag_regacc_pkg.sv
// Shared types for the debug register-access port.
// State encoding, retry sizing and register bus widths.
package jtag_regacc_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam int unsigned MAX_RETRY_DEF = 8;
  localparam int unsigned RETRY_W =
    $clog2(MAX_RETRY_DEF + 1);

  typedef logic [RegAddrBus-1:0] reg_addr_t;
  typedef logic [RegBus-1:0]     reg_data_t;
  typedef logic [RETRY_W-1:0]    retry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    reg_data_t data;
  } req_t;

endpackage

// File: rtl/jtag_regacc.sv
// Debug-side register file access with execute-stage
// collision handling, bounded retry and a registered response.
module jtag_regacc
  import jtag_regacc_pkg::*;
#(
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [RegAddrBus-1:0] req_addr_i,
  input  logic [RegBus-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [RegBus-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              jtag_we_o,
  output logic [RegAddrBus-1:0] jtag_addr_o,
  output logic [RegBus-1:0] jtag_data_o,
  input  logic [RegBus-1:0] jtag_data_i,
  input  logic              ex_we_i,
  input  logic [RegAddrBus-1:0] ex_waddr_i
);

  state_e state_q, state_d;
  req_t   req_q;
  retry_t cnt_q;

  logic hs_req, hs_rsp;
  logic in_access, addr_nz;
  logic collide, retry_max;
  logic done, fail;

  assign in_access = (state_q == ST_ACCESS);
  assign addr_nz   = (req_q.addr != '0);
  assign hs_req    = req_valid_i && req_ready_o;
  assign hs_rsp    = rsp_valid_o && rsp_ready_i;
  assign retry_max = (cnt_q == retry_t'(MAX_RETRY));

  // x0 never collides; execute always wins a write port clash
  always_comb begin
    collide = 1'b0;
    if (in_access && addr_nz && ex_we_i) begin
      if (req_q.we) collide = (ex_waddr_i != '0);
      else          collide = (ex_waddr_i == req_q.addr);
    end
  end

  assign done = in_access && !collide;
  assign fail = in_access && collide && retry_max;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (hs_req) state_d = ST_ACCESS;
      ST_ACCESS: if (done || fail) state_d = ST_RESP;
      ST_RESP:   if (hs_rsp) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (hs_req) begin
        req_q <= '{we: req_we_i,
                   addr: req_addr_i,
                   data: req_data_i};
        cnt_q <= '0;
      end
      if (in_access && collide && !retry_max)
        cnt_q <= cnt_q + retry_t'(1);
      if (done) begin
        rsp_data_o <= (!req_q.we && addr_nz) ?
                      jtag_data_i : '0;
        rsp_err_o  <= 1'b0;
      end
      if (fail) begin
        rsp_data_o <= '0;
        rsp_err_o  <= 1'b1;
      end
      // valid trails RESP entry by one edge
      if (hs_rsp) begin
        rsp_valid_o <= 1'b0;
        rsp_data_o  <= '0;
        rsp_err_o   <= 1'b0;
      end else if (state_q == ST_RESP) begin
        rsp_valid_o <= 1'b1;
      end
    end
  end

  assign req_ready_o = rst && (state_q == ST_IDLE);
  assign jtag_we_o   = in_access && req_q.we && addr_nz;
  assign jtag_addr_o = in_access ? req_q.addr : '0;
  assign jtag_data_o = in_access ? req_q.data : '0;

endmodule

// File: tb/tb_jtag_regacc.sv
// Directed bench for jtag_regacc: latency, collisions,
// retry exhaustion, x0 handling, stall and reset abort.
module tb_jtag_regacc;

  logic        clk;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic        req_we_i;
  logic [4:0]  req_addr_i;
  logic [31:0] req_data_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        jtag_we_o;
  logic [4:0]  jtag_addr_o;
  logic [31:0] jtag_data_o, jtag_data_i;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;

  int total;
  int passed;

  jtag_regacc #(.MAX_RETRY(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .jtag_we_o   (jtag_we_o),
    .jtag_addr_o (jtag_addr_o),
    .jtag_data_o (jtag_data_o),
    .jtag_data_i (jtag_data_i),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ack();
    @(negedge clk); rsp_ready_i = 1'b1;
    @(negedge clk); rsp_ready_i = 1'b0;
  endtask

  // Issues one request; reports negedges until rsp_valid
  // (0 on timeout) and cycles with jtag_we_o high.
  task automatic run_req(
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    input  int          ex_cyc,
    input  logic [4:0]  ex_addr,
    output int          lat,
    output int          wec
  );
    lat = 0;
    wec = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_data_i  = data;
    ex_waddr_i  = ex_addr;
    ex_we_i     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      if (jtag_we_o) wec++;
      if (rsp_valid_o) begin
        lat = i + 1;
        break;
      end
      ex_we_i = (i < ex_cyc);
    end
    ex_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({req_ready_o, rsp_valid_o, jtag_we_o,
         rsp_err_o} !== 4'b0) begin
      $display("FAIL reset_flags: got %b want 0000",
        {req_ready_o, rsp_valid_o, jtag_we_o, rsp_err_o});
    end else passed++;
    total++;
    if ({jtag_addr_o, jtag_data_o, rsp_data_o} !== '0)
      $display("FAIL reset_buses: got %h/%h/%h want 0",
        jtag_addr_o, jtag_data_o, rsp_data_o);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready_o !== 1'b1)
      $display("FAIL reset_ready: got %b want 1",
        req_ready_o);
    else passed++;
  endtask

  task automatic test_write_basic();
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 5'd5;
    req_data_i  = 32'hDEADBEEF;
    @(negedge clk);
    req_valid_i = 1'b0;
    total++;
    if ({jtag_we_o, jtag_addr_o, jtag_data_o,
         req_ready_o} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0})
      $display("FAIL wr5_access: got %b %h %h %b",
        jtag_we_o, jtag_addr_o, jtag_data_o, req_ready_o);
    else passed++;
    @(negedge clk);
    total++;
    if ({jtag_we_o, rsp_valid_o} !== 2'b00)
      $display("FAIL wr5_n1: got we=%b vld=%b want 0 0",
        jtag_we_o, rsp_valid_o);
    else passed++;
    @(negedge clk);
    total++;
    if ({rsp_valid_o, rsp_err_o, rsp_data_o} !==
        {1'b1, 1'b0, 32'h0})
      $display("FAIL wr5_rsp: got %b %b %h want 1 0 0",
        rsp_valid_o, rsp_err_o, rsp_data_o);
    else passed++;
    ack();
    total++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01)
      $display("FAIL wr5_ack: got vld=%b rdy=%b want 0 1",
        rsp_valid_o, req_ready_o);
    else passed++;
  endtask

  task automatic test_write_collision();
    int lat, wec;
    run_req(1'b1, 5'd7, 32'h11223344, 2, 5'd3, lat, wec);
    total++;
    if (wec !== 3)
      $display("FAIL wr7_we_cycles: got %0d want 3", wec);
    else passed++;
    total++;
    if (lat !== 5)
      $display("FAIL wr7_latency: got %0d want 5", lat);
    else passed++;
    total++;
    if ({rsp_err_o, rsp_data_o} !== 33'h0)
      $display("FAIL wr7_rsp: got err=%b data=%h want 0 0",
        rsp_err_o, rsp_data_o);
    else passed++;
    ack();
    run_req(1'b1, 5'd5, 32'h5, 3, 5'd0, lat, wec);
    total++;
    if ({lat, wec} !== {32'd3, 32'd1})
      $display("FAIL wr_ex_x0: got lat=%0d we=%0d want 3 1",
        lat, wec);
    else passed++;
    ack();
  endtask

  task automatic test_read();
    int lat, wec;
    jtag_data_i = 32'hCAFEF00D;
    run_req(1'b0, 5'd4, 32'h0, 3, 5'd3, lat, wec);
    total++;
    if ({lat, wec} !== {32'd3, 32'd0})
      $display("FAIL rd4_timing: got lat=%0d we=%0d want 3 0",
        lat, wec);
    else passed++;
    total++;
    if ({rsp_err_o, rsp_data_o} !== {1'b0, 32'hCAFEF00D})
      $display("FAIL rd4_data: got %b %h want 0 cafef00d",
        rsp_err_o, rsp_data_o);
    else passed++;
    ack();
    jtag_data_i = 32'h01234567;
    run_req(1'b0, 5'd9, 32'h0, 8, 5'd9, lat, wec);
    total++;
    if ({lat, rsp_err_o, rsp_data_o} !==
        {32'd11, 1'b0, 32'h01234567})
      $display("FAIL rd9_8retry: got %0d %b %h want 11 0 01234567",
        lat, rsp_err_o, rsp_data_o);
    else passed++;
    ack();
    run_req(1'b0, 5'd9, 32'h0, 20, 5'd9, lat, wec);
    total++;
    if ({lat, rsp_err_o, rsp_data_o} !== {32'd11, 1'b1, 32'h0})
      $display("FAIL rd9_exhaust: got %0d %b %h want 11 1 0",
        lat, rsp_err_o, rsp_data_o);
    else passed++;
    ack();
  endtask

  task automatic test_x0();
    int lat, wec;
    jtag_data_i = 32'hFFFF0000;
    run_req(1'b0, 5'd0, 32'h0, 5, 5'd0, lat, wec);
    total++;
    if ({lat, wec, rsp_err_o, rsp_data_o} !==
        {32'd3, 32'd0, 1'b0, 32'h0})
      $display("FAIL rd0: got %0d %0d %b %h want 3 0 0 0",
        lat, wec, rsp_err_o, rsp_data_o);
    else passed++;
    ack();
    run_req(1'b1, 5'd0, 32'hABCD, 5, 5'd3, lat, wec);
    total++;
    if ({lat, wec, rsp_err_o, rsp_data_o} !==
        {32'd3, 32'd0, 1'b0, 32'h0})
      $display("FAIL wr0: got %0d %0d %b %h want 3 0 0 0",
        lat, wec, rsp_err_o, rsp_data_o);
    else passed++;
    ack();
  endtask

  task automatic test_back_to_back();
    int lat, wec;
    int bad;
    jtag_data_i = 32'h0BADCAFE;
    run_req(1'b0, 5'd12, 32'h0, 0, 5'd0, lat, wec);
    jtag_data_i = 32'h77777777;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 5'd14;
    req_data_i  = 32'h14141414;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({rsp_valid_o, rsp_data_o, req_ready_o} !==
          {1'b1, 32'h0BADCAFE, 1'b0}) bad++;
    end
    total++;
    if (bad !== 0 || lat !== 3)
      $display("FAIL stall_stable: got %0d bad lat=%0d want 0 3",
        bad, lat);
    else passed++;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    total++;
    if ({rsp_valid_o, req_ready_o, jtag_we_o} !== 3'b010)
      $display("FAIL b2b_gap: got %b want 010",
        {rsp_valid_o, req_ready_o, jtag_we_o});
    else passed++;
    @(negedge clk);
    req_valid_i = 1'b0;
    total++;
    if ({jtag_we_o, jtag_addr_o, jtag_data_o} !==
        {1'b1, 5'd14, 32'h14141414})
      $display("FAIL b2b_second: got %b %h %h want 1 0e 14141414",
        jtag_we_o, jtag_addr_o, jtag_data_o);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if ({rsp_valid_o, rsp_err_o} !== 2'b10)
      $display("FAIL b2b_rsp: got %b want 10",
        {rsp_valid_o, rsp_err_o});
    else passed++;
    ack();
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 5'd6;
    req_data_i  = 32'h66;
    ex_we_i     = 1'b1;
    ex_waddr_i  = 5'd2;
    @(negedge clk);
    req_valid_i = 1'b0;
    total++;
    if (jtag_we_o !== 1'b1)
      $display("FAIL rstmid_pre: got we=%b want 1", jtag_we_o);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({jtag_we_o, jtag_addr_o, jtag_data_o,
         req_ready_o, rsp_valid_o} !== '0)
      $display("FAIL rstmid_async: got %b %h %h %b %b want 0",
        jtag_we_o, jtag_addr_o, jtag_data_o,
        req_ready_o, rsp_valid_o);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    ex_we_i = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_o || jtag_we_o) seen++;
    end
    total++;
    if (seen !== 0 || req_ready_o !== 1'b1)
      $display("FAIL rstmid_discard: got %0d rdy=%b want 0 1",
        seen, req_ready_o);
    else passed++;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    rst         = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    rsp_ready_i = 1'b0;
    jtag_data_i = '0;
    ex_we_i     = 1'b0;
    ex_waddr_i  = '0;
    test_reset();
    test_write_basic();
    test_write_collision();
    test_read();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
